chan_debounce_reduce: RTL



---
 rtl/chan_debounce_reduce_if.sv | 22 ++
 rtl/chan_debounce_reduce.sv | 108 ++++++++++
 2 files changed

// File: rtl/chan_debounce_reduce_if.sv
// rtl/chan_debounce_reduce_if.sv - channel inputs, mask/clear controls and conditioned results
interface chan_debounce_reduce_if #(
   parameter int CHAN_WIDTH = 4
);
   logic [CHAN_WIDTH-1:0] in_i;
   logic [CHAN_WIDTH-1:0] mask_i;
   logic                  clr_i;
   logic [CHAN_WIDTH-1:0] filt_o;
   logic                  x_o;
   logic                  chg_o;
   logic                  stable_o;

   modport master (
      output in_i, mask_i, clr_i,
      input  filt_o, x_o, chg_o, stable_o
   );

   modport slave (
      input  in_i, mask_i, clr_i,
      output filt_o, x_o, chg_o, stable_o
   );
endinterface

// File: rtl/chan_debounce_reduce.sv
// rtl/chan_debounce_reduce.sv - per-channel sync + debounce, masked AND/OR/XOR reduction to one flag
module chan_debounce_reduce #(
   parameter int   CHAN_WIDTH  = 4,
   parameter int   SYNC_STAGES = 2,
   parameter int   DEB_LIMIT   = 8,
   parameter int   MODE        = 0,
   parameter logic RST_VAL     = 1'b0
) (
   input logic                   main_clk_i,
   input logic                   main_rst_an_i,
   chan_debounce_reduce_if.slave bus
);
   localparam int               CNT_W    = $clog2(DEB_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_LIMIT - 1);

   if (MODE < 0 || MODE > 2) begin : g_bad_mode
      $error("chan_debounce_reduce: MODE must be 0 (AND), 1 (OR) or 2 (XOR)");
   end
   if (CHAN_WIDTH < 1 || CHAN_WIDTH > 32 || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
       DEB_LIMIT < 1 || DEB_LIMIT > 255) begin : g_bad_range
      $error("chan_debounce_reduce: parameter out of range");
   end

   logic [CHAN_WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [CHAN_WIDTH-1:0] sync_d [SYNC_STAGES];
   logic [CHAN_WIDTH-1:0] filt_q;
   logic [CHAN_WIDTH-1:0] filt_d;
   logic [CNT_W-1:0]      cnt_q [CHAN_WIDTH];
   logic [CNT_W-1:0]      cnt_d [CHAN_WIDTH];
   logic                  x_q;
   logic                  x_d;
   logic                  chg_q;
   logic                  chg_d;
   logic [CHAN_WIDTH-1:0] s;
   logic [CHAN_WIDTH-1:0] red_in;
   logic                  cnt_idle;

   assign s = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d[0] = bus.in_i;
      for (int k = 1; k < SYNC_STAGES; k++) begin
         sync_d[k] = sync_q[k-1];
      end
   end

   // A mismatch must survive DEB_LIMIT consecutive samples; any match restarts the count.
   always_comb begin
      filt_d   = filt_q;
      cnt_idle = 1'b1;
      for (int n = 0; n < CHAN_WIDTH; n++) begin
         cnt_d[n] = '0;
         if (cnt_q[n] != '0) begin
            cnt_idle = 1'b0;
         end
         if (bus.clr_i) begin
            filt_d[n] = s[n];
         end else if (s[n] != filt_q[n]) begin
            if (cnt_q[n] == CNT_LAST) begin
               filt_d[n] = s[n];
            end else begin
               cnt_d[n] = cnt_q[n] + CNT_W'(1);
            end
         end
      end
   end

   // Masked-out channels are forced to the neutral element of the selected operator.
   always_comb begin
      if (MODE == 0) begin
         red_in = filt_q | ~bus.mask_i;
         x_d    = &red_in;
      end else if (MODE == 1) begin
         red_in = filt_q & bus.mask_i;
         x_d    = |red_in;
      end else begin
         red_in = filt_q & bus.mask_i;
         x_d    = ^red_in;
      end
      chg_d = x_d ^ x_q;
   end

   always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
      if (!main_rst_an_i) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= {CHAN_WIDTH{RST_VAL}};
         end
         for (int n = 0; n < CHAN_WIDTH; n++) begin
            cnt_q[n] <= '0;
         end
         filt_q <= {CHAN_WIDTH{RST_VAL}};
         x_q    <= 1'b0;
         chg_q  <= 1'b0;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
         filt_q <= filt_d;
         x_q    <= x_d;
         chg_q  <= chg_d;
      end
   end

   assign bus.filt_o   = filt_q;
   assign bus.x_o      = x_q;
   assign bus.chg_o    = chg_q;
   assign bus.stable_o = cnt_idle && (s == filt_q);

endmodule
